// File: rtl/tetris_grid_writer_if.sv
// Request channel from the Tetris game logic into tetris_grid_writer.
// The master (game logic) offers one cell update per handshake. The slave
// (grid writer) returns req_ready.
interface tetris_grid_writer_if #(
  parameter int COLOR_W = 4
) ();
  logic               req_valid;
  logic               req_ready;
  logic [4:0]         req_x;
  logic [3:0]         req_y;
  logic [COLOR_W-1:0] req_color;

  modport master (
    output req_valid,
    output req_x,
    output req_y,
    output req_color,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_x,
    input  req_y,
    input  req_color,
    output req_ready
  );
endinterface

// File: rtl/tetris_grid_writer.sv
// tetris_grid_writer: write-side companion of the VGA framebuffer.
// Cell updates from the game logic are queued in a small FIFO, which holds
// one tetromino. Each update is converted to a linear grid RAM address
// (y*GRID_WIDTH + x) and written one per cycle in arrival order. A clear
// sequence fills the whole grid with one colour.
//
// Optional feature macro: GRID_WRITER_VBLANK_GATE_EN. When it is defined,
// RAM writes are only issued in cycles where vblank is high. A clear pauses
// in place and resumes later. When it is undefined, vblank is ignored.
//
// state | meaning
// IDLE  | accepting requests, draining FIFO into grid RAM
// CLEAR | sweeping addresses 0..last with the latched clear colour
module tetris_grid_writer #(
  parameter int BLOCK_SIZE   = 32,
  parameter int VIDEO_WIDTH  = 640,
  parameter int VIDEO_HEIGHT = 480,
  parameter int COLOR_W      = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 RESET_n,
  tetris_grid_writer_if.slave  req_if,
  input  logic                 clear_start,
  input  logic [COLOR_W-1:0]   clear_color,
  input  logic                 vblank,
  output logic                 wr_en,
  output logic [8:0]           wr_addr,
  output logic [COLOR_W-1:0]   wr_data,
  output logic                 busy,
  output logic                 err_oob
);
  localparam int GRID_WIDTH  = VIDEO_WIDTH / BLOCK_SIZE;
  localparam int GRID_HEIGHT = VIDEO_HEIGHT / BLOCK_SIZE;
  localparam logic [8:0] LAST_ADDR = 9'(GRID_WIDTH * GRID_HEIGHT - 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t             state;
  logic [8:0]         clr_addr;
  logic [COLOR_W-1:0] clr_color;

  logic [8:0]         fifo_addr  [FIFO_DEPTH];
  logic [COLOR_W-1:0] fifo_color [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_cnt;

  logic       permit;
  logic       in_idle;
  logic       fifo_full;
  logic       fifo_empty;
  logic       handshake;
  logic       req_oob;
  logic       push;
  logic       pop;
  logic [8:0] push_addr;

`ifdef GRID_WRITER_VBLANK_GATE_EN
  assign permit = vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign permit        = 1'b1;
`endif

  assign in_idle    = (state == ST_IDLE);
  assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);

  // A clear request always wins over a request in the same cycle.
  assign req_if.req_ready = in_idle && !fifo_full && !clear_start;
  assign handshake        = req_if.req_valid && req_if.req_ready;

  assign req_oob = ({4'd0, req_if.req_x} >= 9'(GRID_WIDTH)) ||
                   ({5'd0, req_if.req_y} >= 9'(GRID_HEIGHT));
  assign push_addr = {5'd0, req_if.req_y} * 9'(GRID_WIDTH) + {4'd0, req_if.req_x};

  // An out-of-bounds request completes its handshake but is never stored.
  assign push = handshake && !req_oob;
  // The pop uses the pre-edge FIFO contents, so a request cannot pass
  // straight through in the cycle it is accepted.
  assign pop  = in_idle && !fifo_empty && permit && !clear_start;

  assign busy = !in_idle || !fifo_empty || wr_en;

  // FIFO storage; entries carry the precomputed linear address.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr]  <= push_addr;
      fifo_color[wr_ptr] <= req_if.req_color;
    end
  end

  // Control FSM, FIFO pointers and registered RAM write port.
  always_ff @(posedge clk) begin
    if (!RESET_n) begin
      state     <= ST_IDLE;
      clr_addr  <= '0;
      clr_color <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      err_oob   <= 1'b0;
    end else begin
      wr_en   <= 1'b0;
      err_oob <= handshake && req_oob;
      case (state)
        ST_IDLE: begin
          if (clear_start) begin
            state     <= ST_CLEAR;
            clr_addr  <= '0;
            clr_color <= clear_color;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
          end else begin
            if (push) begin
              wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
              rd_ptr  <= rd_ptr + PTR_W'(1);
              wr_en   <= 1'b1;
              wr_addr <= fifo_addr[rd_ptr];
              wr_data <= fifo_color[rd_ptr];
            end
            fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
          end
        end
        ST_CLEAR: begin
          if (permit) begin
            wr_en   <= 1'b1;
            wr_addr <= clr_addr;
            wr_data <= clr_color;
            if (clr_addr == LAST_ADDR) begin
              state <= ST_IDLE;
            end else begin
              clr_addr <= clr_addr + 9'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tetris_grid_writer.sv
// Testbench for tetris_grid_writer. A queue-based behavioural model predicts
// every RAM write, err_oob, busy and req_ready. A compare process checks the
// DUT against it on each falling edge. Directed sequences add literal
// expectations for the key scenarios.
module tb_tetris_grid_writer;
  localparam int COLOR_W    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int GRID_W     = 20;
  localparam int GRID_H     = 15;
  localparam int NCELLS     = GRID_W * GRID_H;

  logic         clk = 1'b0;
  logic         RESET_n;
  logic         clear_start;
  logic [3:0]   clear_color;
  logic         vblank;
  logic         wr_en;
  logic [8:0]   wr_addr;
  logic [3:0]   wr_data;
  logic         busy;
  logic         err_oob;

  int n_checks = 0;
  int n_errors = 0;

  tetris_grid_writer_if #(.COLOR_W(COLOR_W)) req_if ();

  tetris_grid_writer #(
    .BLOCK_SIZE(32), .VIDEO_WIDTH(640), .VIDEO_HEIGHT(480),
    .COLOR_W(COLOR_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .RESET_n(RESET_n), .req_if(req_if),
    .clear_start(clear_start), .clear_color(clear_color), .vblank(vblank),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .err_oob(err_oob)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int addr; int data; } cell_wr_t;
  cell_wr_t m_fifo[$];
  cell_wr_t m_head;
  bit chk_en = 1'b0;
  bit m_wr_valid = 1'b0;
  bit m_oob = 1'b0;
  bit m_busy = 1'b0;
  bit m_permit;
  bit m_ready;
  int m_wr_addr = 0;
  int m_wr_data = 0;
  int m_clear_left = 0;
  int m_clr_next = 0;
  int m_clr_col = 0;

  // Model advance on each rising edge using the pre-edge inputs.
  always @(posedge clk) begin
`ifdef GRID_WRITER_VBLANK_GATE_EN
    m_permit = vblank;
`else
    m_permit = 1'b1;
`endif
    m_ready = (m_clear_left == 0) && (m_fifo.size() < FIFO_DEPTH) && !clear_start;
    m_wr_valid = 1'b0;
    m_oob = 1'b0;
    if (!RESET_n) begin
      m_fifo.delete();
      m_clear_left = 0;
    end else if (m_clear_left > 0) begin
      if (m_permit) begin
        m_wr_valid = 1'b1;
        m_wr_addr = m_clr_next;
        m_wr_data = m_clr_col;
        m_clr_next++;
        m_clear_left--;
      end
    end else if (clear_start) begin
      m_fifo.delete();
      m_clear_left = NCELLS;
      m_clr_next = 0;
      m_clr_col = int'(clear_color);
    end else begin
      if (m_fifo.size() > 0 && m_permit) begin
        m_head = m_fifo.pop_front();
        m_wr_valid = 1'b1;
        m_wr_addr = m_head.addr;
        m_wr_data = m_head.data;
      end
      if (req_if.req_valid && m_ready) begin
        if (int'(req_if.req_x) >= GRID_W || int'(req_if.req_y) >= GRID_H)
          m_oob = 1'b1;
        else
          m_fifo.push_back('{addr: int'(req_if.req_y) * GRID_W + int'(req_if.req_x),
                             data: int'(req_if.req_color)});
      end
    end
    m_busy = (m_clear_left > 0) || (m_fifo.size() > 0) || m_wr_valid;
    chk_en = 1'b1;
  end

  // Compare DUT against the model mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_wr_en", 32'(wr_en), 32'(m_wr_valid));
      if (m_wr_valid) begin
        check("m_wr_addr", 32'(wr_addr), 32'(m_wr_addr));
        check("m_wr_data", 32'(wr_data), 32'(m_wr_data));
      end
      check("m_err_oob", 32'(err_oob), 32'(m_oob));
      check("m_busy", 32'(busy), 32'(m_busy));
      check("m_req_ready", 32'(req_if.req_ready),
            32'((m_clear_left == 0) && (m_fifo.size() < FIFO_DEPTH) && !clear_start));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input int x, input int y, input int c);
    req_if.req_valid = 1'b1;
    req_if.req_x     = 5'(x);
    req_if.req_y     = 4'(y);
    req_if.req_color = 4'(c);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_wait", 32'(busy), 32'd0);
    tick();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int  n;
  bit  addr_ok;
  bit  busy_ok;
  bit  found;

  initial begin
    // Reset with random inputs.
    RESET_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_if.req_valid = 1'($urandom_range(0, 1));
      req_if.req_x     = 5'($urandom_range(0, 31));
      req_if.req_y     = 4'($urandom_range(0, 15));
      req_if.req_color = 4'($urandom_range(0, 15));
      clear_start      = 1'($urandom_range(0, 1));
      clear_color      = 4'($urandom_range(0, 15));
      vblank           = 1'($urandom_range(0, 1));
      tick();
    end
    @(negedge clk);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_oob", 32'(err_oob), 32'd0);
    tick();
    RESET_n = 1'b1;
    req_if.req_valid = 1'b0;
    clear_start = 1'b0;
    vblank = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(req_if.req_ready), 32'd1);
    tick();

    // Single write (3,2) colour 5 -> address 43, one cycle later, one cycle long.
    present(3, 2, 5);
    tick();
    req_if.req_valid = 1'b0;
    @(negedge clk);
    check("single_lat0", 32'(wr_en), 32'd0);
    tick();
    @(negedge clk);
    check("single_en", 32'(wr_en), 32'd1);
    check("single_addr", 32'(wr_addr), 32'd43);
    check("single_data", 32'(wr_data), 32'd5);
    tick();
    @(negedge clk);
    check("single_once", 32'(wr_en), 32'd0);
    tick();

    // Corner cell (19,14) -> address 299.
    present(19, 14, 12);
    tick();
    req_if.req_valid = 1'b0;
    tick();
    @(negedge clk);
    check("corner_addr", 32'(wr_addr), 32'd299);
    check("corner_data", 32'(wr_data), 32'd12);
    tick();

    // Out-of-bounds: x=20 and y=15.
    present(20, 0, 3);
    @(negedge clk);
    check("oobx_ready", 32'(req_if.req_ready), 32'd1);
    tick();
    req_if.req_valid = 1'b0;
    @(negedge clk);
    check("oobx_pulse", 32'(err_oob), 32'd1);
    check("oobx_nowr", 32'(wr_en), 32'd0);
    tick();
    @(negedge clk);
    check("oobx_end", 32'(err_oob), 32'd0);
    check("oobx_nowr2", 32'(wr_en), 32'd0);
    tick();
    present(0, 15, 4);
    tick();
    req_if.req_valid = 1'b0;
    @(negedge clk);
    check("ooby_pulse", 32'(err_oob), 32'd1);
    tick();
    @(negedge clk);
    check("ooby_end", 32'(err_oob), 32'd0);
    check("ooby_nowr", 32'(wr_en), 32'd0);
    tick();

`ifdef GRID_WRITER_VBLANK_GATE_EN
    // Outside vblank, four requests fill the FIFO and the fifth is refused.
    vblank = 1'b0;
    for (int i = 0; i < 5; i++) begin
      present(i, 1, i + 1);
      @(negedge clk);
      check("gate_ready", 32'(req_if.req_ready), 32'(i < 4));
      if (i < 4) tick();
    end
    vblank = 1'b1;
    tick();
    @(negedge clk);
    check("gate_first_en", 32'(wr_en), 32'd1);
    check("gate_first_addr", 32'(wr_addr), 32'd20);
    check("gate_fifth_ready", 32'(req_if.req_ready), 32'd1);
    tick();
    req_if.req_valid = 1'b0;
    wait_idle();
`else
    // Back-to-back requests with vblank low: drained every cycle.
    vblank = 1'b0;
    for (int i = 0; i < 5; i++) begin
      present(i, 1, i + 1);
      @(negedge clk);
      check("b2b_ready", 32'(req_if.req_ready), 32'd1);
      tick();
    end
    req_if.req_valid = 1'b0;
    vblank = 1'b1;
    wait_idle();
`endif

    // Clear colour 0 with a concurrent request; vblank toggles during the sweep.
    present(1, 1, 7);
    clear_start = 1'b1;
    clear_color = 4'd0;
    @(negedge clk);
    check("clr_refuse", 32'(req_if.req_ready), 32'd0);
    tick();
    clear_start = 1'b0;
    req_if.req_valid = 1'b0;
    @(negedge clk);
    check("clr_gap", 32'(wr_en), 32'd0);
    check("clr_busy0", 32'(busy), 32'd1);
    n = 0;
    addr_ok = 1'b1;
    busy_ok = 1'b1;
    for (int i = 0; i < 2000 && n < NCELLS; i++) begin
      tick();
      vblank = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      if (wr_en) begin
        if (int'(wr_addr) != n || wr_data != 4'd0) addr_ok = 1'b0;
        n++;
      end
    end
    check("clr_count", 32'(n), 32'(NCELLS));
    check("clr_order", 32'(addr_ok), 32'd1);
    check("clr_busy", 32'(busy_ok), 32'd1);
    vblank = 1'b1;
    tick();
    @(negedge clk);
    check("clr_done_wr", 32'(wr_en), 32'd0);
    check("clr_done_ready", 32'(req_if.req_ready), 32'd1);
    check("clr_done_busy", 32'(busy), 32'd0);
    tick();

    // Clear interrupted by reset at address 150.
    clear_start = 1'b1;
    clear_color = 4'd3;
    tick();
    clear_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (wr_en && wr_addr == 9'd150) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("rst150_reached", 32'(found), 32'd1);
    RESET_n = 1'b0;
    tick();
    @(negedge clk);
    check("rst150_wr", 32'(wr_en), 32'd0);
    check("rst150_busy", 32'(busy), 32'd0);
    RESET_n = 1'b1;
    tick();
    @(negedge clk);
    check("rst150_ready", 32'(req_if.req_ready), 32'd1);
    check("rst150_wr2", 32'(wr_en), 32'd0);
    tick();

    // Clear with queued entries: queued cells are discarded, first write is address 0.
    vblank = 1'b0;
    for (int i = 0; i < 3; i++) begin
      present(2 + i, 3, 6 + i);
      tick();
    end
    req_if.req_valid = 1'b0;
    clear_start = 1'b1;
    clear_color = 4'd9;
    @(negedge clk);
    check("q_clr_ready", 32'(req_if.req_ready), 32'd0);
    tick();
    clear_start = 1'b0;
    vblank = 1'b1;
    @(negedge clk);
    check("q_no_write", 32'(wr_en), 32'd0);
    tick();
    @(negedge clk);
    check("q_first_en", 32'(wr_en), 32'd1);
    check("q_first_addr", 32'(wr_addr), 32'd0);
    check("q_first_data", 32'(wr_data), 32'd9);
    tick();
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
